// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one global memory read/write channel among several client ports.
// One request is in flight at a time; responses are relayed until the client drops its valid.
module mem_arbiter #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned DATA_BITS   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           client_read_valid,
  input  logic [NUM_CLIENTS*ADDR_BITS-1:0] client_read_address,
  output logic [NUM_CLIENTS-1:0]           client_read_ready,
  output logic [NUM_CLIENTS*DATA_BITS-1:0] client_read_data,
  input  logic [NUM_CLIENTS-1:0]           client_write_valid,
  input  logic [NUM_CLIENTS*ADDR_BITS-1:0] client_write_address,
  input  logic [NUM_CLIENTS*DATA_BITS-1:0] client_write_data,
  output logic [NUM_CLIENTS-1:0]           client_write_ready,
  output logic                             mem_read_valid,
  output logic [ADDR_BITS-1:0]             mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [DATA_BITS-1:0]             mem_read_data,
  output logic                             mem_write_valid,
  output logic [ADDR_BITS-1:0]             mem_write_address,
  output logic [DATA_BITS-1:0]             mem_write_data,
  input  logic                             mem_write_ready
);

  localparam int unsigned IdxBits = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  typedef logic [IdxBits-1:0] idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StReadWait,
    StWriteWait,
    StReadRelay,
    StWriteRelay
  } state_e;

  state_e               state_q;
  idx_t                 grant_q;
  idx_t                 last_grant_q;
  logic [DATA_BITS-1:0] rdata_q [NUM_CLIENTS];

  logic [ADDR_BITS-1:0] rd_addr [NUM_CLIENTS];
  logic [ADDR_BITS-1:0] wr_addr [NUM_CLIENTS];
  logic [DATA_BITS-1:0] wr_data [NUM_CLIENTS];
  logic                 pick_found;
  idx_t                 pick_idx;

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      rd_addr[i] = client_read_address[i*ADDR_BITS +: ADDR_BITS];
      wr_addr[i] = client_write_address[i*ADDR_BITS +: ADDR_BITS];
      wr_data[i] = client_write_data[i*DATA_BITS +: DATA_BITS];
      client_read_data[i*DATA_BITS +: DATA_BITS] = rdata_q[i];
    end
  end

  // First requester at or after the client following the previous grant.
  always_comb begin
    idx_t cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      cand = idx_t'((int'(last_grant_q) + k + 1) % int'(NUM_CLIENTS));
      if (!pick_found && (client_read_valid[cand] || client_write_valid[cand])) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= StIdle;
      grant_q            <= '0;
      last_grant_q       <= idx_t'(NUM_CLIENTS - 1);
      client_read_ready  <= '0;
      client_write_ready <= '0;
      mem_read_valid     <= 1'b0;
      mem_read_address   <= '0;
      mem_write_valid    <= 1'b0;
      mem_write_address  <= '0;
      mem_write_data     <= '0;
      for (int i = 0; i < NUM_CLIENTS; i++) rdata_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_q      <= pick_idx;
            last_grant_q <= pick_idx;
            // A read wins over a simultaneous write from the same client.
            if (client_read_valid[pick_idx]) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= rd_addr[pick_idx];
              state_q          <= StReadWait;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= wr_addr[pick_idx];
              mem_write_data    <= wr_data[pick_idx];
              state_q           <= StWriteWait;
            end
          end
        end
        StReadWait: begin
          if (mem_read_ready) begin
            mem_read_valid             <= 1'b0;
            rdata_q[grant_q]           <= mem_read_data;
            client_read_ready[grant_q] <= 1'b1;
            state_q                    <= StReadRelay;
          end
        end
        StWriteWait: begin
          if (mem_write_ready) begin
            mem_write_valid             <= 1'b0;
            client_write_ready[grant_q] <= 1'b1;
            state_q                     <= StWriteRelay;
          end
        end
        StReadRelay: begin
          if (!client_read_valid[grant_q]) begin
            client_read_ready <= '0;
            state_q           <= StIdle;
          end
        end
        StWriteRelay: begin
          if (!client_write_valid[grant_q]) begin
            client_write_ready <= '0;
            state_q            <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: Parameter NUM_CLIENTS, default 4, SHALL set the number of requesting cache/LSU ports sharing one global memory channel.
REQ-002: Parameter ADDR_BITS, default 8, SHALL set the address width; DATA_BITS, default 8, SHALL set the data width.
REQ-003: Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-004: clk  input  1  block clock; all state SHALL update on its rising edge.
REQ-005: reset  input  1  asynchronous, active-low reset (asserted = 0).
REQ-006: client_read_valid  input  NUM_CLIENTS  per-client read request.
REQ-007: client_read_address  input  NUM_CLIENTS*ADDR_BITS  per-client read address; client i at slice i.
REQ-008: client_read_ready  output  NUM_CLIENTS  per-client read completion.
REQ-009: client_read_data  output  NUM_CLIENTS*DATA_BITS  per-client read data.
REQ-010: client_write_valid  input  NUM_CLIENTS  per-client write request.
REQ-011: client_write_address / client_write_data  input  NUM_CLIENTS*ADDR_BITS / NUM_CLIENTS*DATA_BITS  per-client write request payload.
REQ-012: client_write_ready  output  NUM_CLIENTS  per-client write completion.
REQ-013: mem_read_valid, mem_read_address, mem_read_ready (in), mem_read_data (in)  1 / ADDR_BITS / 1 / DATA_BITS  downstream read channel.
REQ-014: mem_write_valid, mem_write_address, mem_write_data, mem_write_ready (in)  1 / ADDR_BITS / DATA_BITS / 1  downstream write channel.

Function
REQ-015: The block SHALL be an FSM with states IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
REQ-016: In IDLE, the block SHALL scan clients starting at (last_grant+1) mod NUM_CLIENTS and select the first one with read_valid or write_valid set.
REQ-017: For a selected client with both read_valid and write_valid set, read SHALL win; the write remains pending.
REQ-018: On selection, the block SHALL register grant index, address and write data, and set last_grant to that index in the same edge.
REQ-019: Read selection: mem_read_valid=1 and mem_read_address=latched address from the next cycle; state -> READ_WAIT.
REQ-020: Write selection: mem_write_valid=1, mem_write_address and mem_write_data latched; state -> WRITE_WAIT.
REQ-021: In READ_WAIT, on mem_read_ready=1 the block SHALL drop mem_read_valid, drive client_read_data[grant]=mem_read_data, assert client_read_ready[grant], state -> READ_RELAY.
REQ-022: In WRITE_WAIT, on mem_write_ready=1 the block SHALL drop mem_write_valid, assert client_write_ready[grant], state -> WRITE_RELAY.
REQ-023: In *_RELAY, ready SHALL be held until the granted client drops its matching valid; then ready -> 0 on the next edge and state -> IDLE.
REQ-024: Minimum per-request occupancy SHALL be: 1 cycle select + memory latency + 1 cycle relay + 1 cycle return to IDLE; no new grant in any non-IDLE state.
REQ-025: Non-granted clients SHALL see read_ready=0, write_ready=0, read_data held at its last value.
REQ-026: At most one of mem_read_valid / mem_write_valid SHALL be 1 in any cycle.
REQ-027: Request changes on a granted client while in *_WAIT SHALL be ignored (latched payload used).
REQ-028: Round-robin pointer SHALL wrap from NUM_CLIENTS-1 to 0; no client starves when all request continuously.

Reset
REQ-029: While reset=0, state SHALL be IDLE, last_grant=NUM_CLIENTS-1 (so client 0 wins first), and all outputs 0, including data/address buses.
REQ-030: Reset asserted mid-transaction SHALL abort it immediately (asynchronously); the outstanding memory request is dropped without response.
REQ-031: After reset release, the first grant SHALL occur on the first rising edge with reset=1.

Verification
REQ-032: Single read: client 2 reads 0x3C, memory returns 0xA5 after 3 cycles -> client_read_ready[2]=1, client_read_data[2]=0xA5, held until read_valid[2] drops.
REQ-033: Single write: client 1 writes 0x7E to 0x10, mem_write_ready after 2 cycles -> mem_write_address=0x10, mem_write_data=0x7E, client_write_ready[1] pulses until valid drops.
REQ-034: All 4 clients read continuously from reset -> grant order 0,1,2,3,0; never two memory valids together.
REQ-035: Client 3 asserts read and write together -> read serviced first, write on its next grant.
REQ-036: Reset driven low during READ_WAIT -> all outputs 0 immediately; after release, client 0 wins if requesting.
REQ-037: Client 0 changes read address 0x05->0x06 during READ_WAIT -> mem_read_address stays 0x05.
